// File: rtl/font_seq_pkg.sv
// font_seq_pkg
// Shared definitions for the font glyph sequencer: FSM state encoding,
// the control-code threshold and the default geometry constants.
package font_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    CMD   = 3'd4
  } state_t;

  // Character codes below this value are LCD control codes, not glyphs
  localparam logic [6:0] CTRL_LIMIT = 7'h20;

  localparam int DEF_GLYPH_BYTES = 8;
  localparam int DEF_ROM_AW      = 10;
  localparam int DEF_FIFO_DEPTH  = 16;

endpackage

// File: rtl/char_fifo.sv
// char_fifo
// Synchronous first-word-fall-through FIFO with an occupancy output.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, wdata      write request and data (ignored when full)
//   pop              read request (ignored when empty)
//   rdata            head entry, valid whenever empty = 0
//   level            current occupancy 0..DEPTH
//   full, empty      occupancy flags
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == DEPTH_L);
  assign empty     = (level_r == {(AW+1){1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/font_glyph_sequencer.sv
// font_glyph_sequencer
// Queues character tokens and renders them onto the LCD byte path. Printable
// codes fetch GLYPH_BYTES rows from a registered-read font ROM (optionally
// inverted); control codes (< 0x20) are forwarded as single command bytes.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   char_valid/data/ready    token input (data[7] = invert, [6:0] = code)
//   rom_rd, rom_addr         ROM read strobe and address {code, row}
//   rom_data                 ROM data, valid the cycle after rom_rd
//   lcd_valid/data/cmd/first output byte with command and first-row marks
//   lcd_ready                LCD writer accepts the byte
//   busy, fifo_level         activity flag and FIFO occupancy
module font_glyph_sequencer
  import font_seq_pkg::*;
#(
  parameter int GLYPH_BYTES = DEF_GLYPH_BYTES,
  parameter int ROM_AW      = DEF_ROM_AW,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          char_valid,
  input  logic [7:0]                    char_data,
  output logic                          char_ready,
  output logic                          rom_rd,
  output logic [ROM_AW-1:0]             rom_addr,
  input  logic [7:0]                    rom_data,
  output logic                          lcd_valid,
  output logic [7:0]                    lcd_data,
  output logic                          lcd_cmd,
  output logic                          lcd_first,
  input  logic                          lcd_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ROW_W = $clog2(GLYPH_BYTES);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_BYTES - 1);

  state_t            state_r, state_s;
  logic [7:0]        cur_r, cur_s;
  logic [ROW_W-1:0]  row_r, row_s;
  logic              rom_rd_r, rom_rd_s;
  logic [ROM_AW-1:0] rom_addr_r, rom_addr_s;
  logic              lcd_valid_r, lcd_valid_s;
  logic [7:0]        lcd_data_r, lcd_data_s;
  logic              lcd_cmd_r, lcd_cmd_s;
  logic              lcd_first_r, lcd_first_s;
  logic              pop_s;
  logic [7:0]        fifo_rdata_s;
  logic [LVL_W-1:0]  level_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // {code, row} widened before truncation so any ROM_AW is legal
  function automatic logic [ROM_AW-1:0] glyph_addr(input logic [6:0] code,
                                                   input logic [ROW_W-1:0] row);
    logic [ROM_AW+7+ROW_W-1:0] wide;
    wide = {{ROM_AW{1'b0}}, code, row};
    return wide[ROM_AW-1:0];
  endfunction

  char_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (char_valid),
    .pop   (pop_s),
    .wdata (char_data),
    .rdata (fifo_rdata_s),
    .level (level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign char_ready = ~fifo_full_s;
  assign fifo_level = level_s;
  assign busy       = (state_r != IDLE) | (level_s != {LVL_W{1'b0}});
  assign rom_rd     = rom_rd_r;
  assign rom_addr   = rom_addr_r;
  assign lcd_valid  = lcd_valid_r;
  assign lcd_data   = lcd_data_r;
  assign lcd_cmd    = lcd_cmd_r;
  assign lcd_first  = lcd_first_r;

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cur_r       <= 8'h00;
      row_r       <= {ROW_W{1'b0}};
      rom_rd_r    <= 1'b0;
      rom_addr_r  <= {ROM_AW{1'b0}};
      lcd_valid_r <= 1'b0;
      lcd_data_r  <= 8'h00;
      lcd_cmd_r   <= 1'b0;
      lcd_first_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      row_r       <= row_s;
      rom_rd_r    <= rom_rd_s;
      rom_addr_r  <= rom_addr_s;
      lcd_valid_r <= lcd_valid_s;
      lcd_data_r  <= lcd_data_s;
      lcd_cmd_r   <= lcd_cmd_s;
      lcd_first_r <= lcd_first_s;
    end
  end

  // Next-state logic; rom_rd/rom_addr are set on entry to FETCH so the
  // strobe is registered yet still high exactly during the FETCH cycle
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    row_s       = row_r;
    rom_rd_s    = 1'b0;
    rom_addr_s  = rom_addr_r;
    lcd_valid_s = lcd_valid_r;
    lcd_data_s  = lcd_data_r;
    lcd_cmd_s   = lcd_cmd_r;
    lcd_first_s = lcd_first_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          cur_s = fifo_rdata_s;
          if (fifo_rdata_s[6:0] < CTRL_LIMIT) begin
            state_s     = CMD;
            lcd_valid_s = 1'b1;
            lcd_cmd_s   = 1'b1;
            lcd_first_s = 1'b0;
            lcd_data_s  = {1'b0, fifo_rdata_s[6:0]};
          end else begin
            state_s    = FETCH;
            row_s      = {ROW_W{1'b0}};
            rom_rd_s   = 1'b1;
            rom_addr_s = glyph_addr(fifo_rdata_s[6:0], {ROW_W{1'b0}});
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = CAPT;
      end
      CAPT: begin
        state_s     = SEND;
        lcd_valid_s = 1'b1;
        lcd_cmd_s   = 1'b0;
        lcd_data_s  = rom_data ^ {8{cur_r[7]}};
        lcd_first_s = (row_r == {ROW_W{1'b0}});
      end
      SEND: begin
        if (lcd_ready) begin
          lcd_valid_s = 1'b0;
          lcd_first_s = 1'b0;
          if (row_r == LAST_ROW) begin
            state_s = IDLE;
          end else begin
            state_s    = FETCH;
            row_s      = row_r + ROW_W'(1);
            rom_rd_s   = 1'b1;
            rom_addr_s = glyph_addr(cur_r[6:0], row_r + ROW_W'(1));
          end
        end else begin
          state_s = SEND;
        end
      end
      CMD: begin
        if (lcd_ready) begin
          state_s     = IDLE;
          lcd_valid_s = 1'b0;
          lcd_cmd_s   = 1'b0;
        end else begin
          state_s = CMD;
        end
      end
      default: begin
        state_s     = IDLE;
        lcd_valid_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_font_glyph_sequencer.sv
module tb_font_glyph_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       rom_rd;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic       lcd_valid;
  logic [7:0] lcd_data;
  logic       lcd_cmd;
  logic       lcd_first;
  logic       lcd_ready;
  logic       busy;
  logic [4:0] fifo_level;

  typedef struct packed {
    logic [7:0] data;
    logic       cmd;
    logic       first;
  } beat_t;

  beat_t      exp_q[$];
  logic [9:0] addr_q[$];
  int         checks = 0;
  int         failures = 0;
  int         acc_cnt = 0;
  logic       stall_r = 1'b0;
  logic [7:0] stall_data_r = 8'h00;
  logic       stall_first_r = 1'b0;

  always #5 clk = ~clk;

  font_glyph_sequencer #(.GLYPH_BYTES(8), .ROM_AW(10), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .lcd_valid  (lcd_valid),
    .lcd_data   (lcd_data),
    .lcd_cmd    (lcd_cmd),
    .lcd_first  (lcd_first),
    .lcd_ready  (lcd_ready),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // Font ROM model: registered read returning the low address byte
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_addr[7:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Glyph at ROM base address: rows return base[7:0]+r, optionally inverted
  task automatic expect_glyph(input logic [9:0] base, input logic inv);
    beat_t b;
    for (int r = 0; r < 8; r++) begin
      addr_q.push_back(base + 10'(r));
      b.data  = (base[7:0] + 8'(r)) ^ {8{inv}};
      b.cmd   = 1'b0;
      b.first = (r == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic expect_cmd(input logic [6:0] code);
    beat_t b;
    b.data  = {1'b0, code};
    b.cmd   = 1'b1;
    b.first = 1'b0;
    exp_q.push_back(b);
  endtask

  // Offer one token; expectation is queued at the moment it is accepted
  task automatic push(input logic [7:0] tok, input logic is_cmd, input logic [9:0] base);
    logic ok;
    ok = 1'b0;
    char_data  = tok;
    char_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (char_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push_accepted", {31'd0, ok}, 32'd1);
    if (ok) begin
      if (is_cmd) expect_cmd(tok[6:0]);
      else        expect_glyph(base, tok[7]);
      @(posedge clk);
    end
    #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!busy && !lcd_valid && exp_q.size() == 0) break;
    end
    chk("drain_exp_q", exp_q.size(), 32'd0);
    chk("drain_addr_q", addr_q.size(), 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: ROM reads, accepted LCD bytes and stall stability
  always @(negedge clk) begin
    beat_t      e;
    logic [9:0] ea;
    if (reset) begin
      stall_r <= 1'b0;
    end else begin
      if (rom_rd) begin
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rom_rd_unexpected actual=0x%0h expected=none", rom_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("rom_addr", {22'd0, rom_addr}, {22'd0, ea});
        end
      end
      if (stall_r) begin
        chk("stall_valid", {31'd0, lcd_valid}, 32'd1);
        chk("stall_data", {24'd0, lcd_data}, {24'd0, stall_data_r});
        chk("stall_first", {31'd0, lcd_first}, {31'd0, stall_first_r});
      end
      if (lcd_valid && lcd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL lcd_unexpected actual=0x%0h expected=none", lcd_data);
        end else begin
          e = exp_q.pop_front();
          chk("lcd_data", {24'd0, lcd_data}, {24'd0, e.data});
          chk("lcd_cmd", {31'd0, lcd_cmd}, {31'd0, e.cmd});
          chk("lcd_first", {31'd0, lcd_first}, {31'd0, e.first});
        end
        acc_cnt++;
      end
      stall_r       <= lcd_valid && !lcd_ready;
      stall_data_r  <= lcd_data;
      stall_first_r <= lcd_first;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int fv;
    int start;
    reset = 1'b1; char_valid = 1'b0; char_data = 8'h00; lcd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_ready", {31'd0, char_ready}, 32'd1);
    chk("rst_lcd_valid", {31'd0, lcd_valid}, 32'd0);
    chk("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_lcd_cmd_first", {30'd0, lcd_cmd, lcd_first}, 32'd0);
    chk("rst_rom", {21'd0, rom_rd, rom_addr}, 32'd0);
    chk("rst_busy_level", {26'd0, busy, fifo_level}, 32'd0);
    reset = 1'b0;

    // 'A': latency and busy duration from an idle, empty block
    push(8'h41, 1'b0, 10'h208);
    n = 0; fv = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      n++;
      if (lcd_valid && fv == 0) fv = n;
      if (!busy) break;
    end
    chk("first_valid_latency", fv, 32'd3);
    chk("busy_drop_cycles", n, 32'd25);
    wait_idle();

    // Inverted 'A'
    push(8'hC1, 1'b0, 10'h208);
    wait_idle();

    // Control code then 'B'
    push(8'h0A, 1'b1, 10'h000);
    push(8'h42, 1'b0, 10'h210);
    wait_idle();

    // 'D' with a 10-cycle stall on the third byte
    start = acc_cnt;
    push(8'h44, 1'b0, 10'h220);
    for (int i = 0; i < 100 && acc_cnt != start + 2; i++) begin
      @(posedge clk); #1;
    end
    lcd_ready = 1'b0;
    for (int i = 0; i < 20 && !lcd_valid; i++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("stall_no_accept", acc_cnt, start + 2);
    lcd_ready = 1'b1;
    wait_idle();

    // FIFO fill under backpressure: 17 accepted, 18th held by the source
    lcd_ready = 1'b0;
    start = acc_cnt;
    fork
      begin
        push(8'h43, 1'b0, 10'h218);
        for (int k = 1; k <= 17; k++) push(8'(k), 1'b1, 10'h000);
      end
      begin
        repeat (30) @(posedge clk);
        #2;
        chk("full_level", {27'd0, fifo_level}, 32'd16);
        chk("full_char_ready", {31'd0, char_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        chk("full_no_accept", acc_cnt, start);
        lcd_ready = 1'b1;
      end
    join
    wait_idle();
    chk("full_all_emitted", acc_cnt, start + 25);

    // Reset during the 4th byte with three tokens queued
    start = acc_cnt;
    push(8'h45, 1'b0, 10'h228);
    push(8'h46, 1'b0, 10'h230);
    push(8'h47, 1'b0, 10'h238);
    push(8'h48, 1'b0, 10'h240);
    for (int i = 0; i < 100 && acc_cnt != start + 3; i++) begin
      @(posedge clk); #1;
    end
    lcd_ready = 1'b0;
    for (int i = 0; i < 20 && !lcd_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_level", {27'd0, fifo_level}, 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    addr_q.delete();
    chk("post_reset_lcd_valid", {31'd0, lcd_valid}, 32'd0);
    chk("post_reset_level", {27'd0, fifo_level}, 32'd0);
    chk("post_reset_char_ready", {31'd0, char_ready}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    lcd_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_reset_no_output", acc_cnt, start + 3);
    chk("final_queues", exp_q.size() + addr_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
